// File: rtl/csa_share_arbiter.sv
// Round-robin front end that time-shares one external carry-select adder.
// The winner's operands are latched and held on add_* for ADD_LAT cycles,
// then the sum is registered and returned with a valid/ready handshake.
module csa_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout,
    input  logic                       rsp_ready
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    // ADD_LAT tops out at 15, so ADD_LAT-1 always fits in 4 bits.
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [IdW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic [IdW-1:0]   win_idx;
    logic             win_found;
    int unsigned      scan_pos;

    // Round-robin search: first set request at or after rr_ptr, wrapping.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_pos  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_pos = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req[IdW'(scan_pos)]) begin
                win_found = 1'b1;
                win_idx   = IdW'(scan_pos);
            end
        end
    end

    // Grant is only offered while idle, so it is one-hot or zero.
    always_comb begin
        gnt = '0;
        if (state_q == StIdle && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lat_cnt_d   = lat_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    op_a_d    = req_a[win_idx*WIDTH +: WIDTH];
                    op_b_d    = req_b[win_idx*WIDTH +: WIDTH];
                    op_cin_d  = req_cin[win_idx];
                    id_d      = win_idx;
                    lat_cnt_d = CntW'(ADD_LAT - 1);
                    rr_ptr_d  = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + IdW'(1);
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - CntW'(1);
                end else begin
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            lat_cnt_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lat_cnt_q   <= lat_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: doc/csa_share_arbiter.md
Name: csa_share_arbiter

Overview:
- Shares one 32-bit combinational carry-select adder (csa) among NUM_REQ requesters.
- Round-robin arbitration; winner's operands are latched and driven onto the adder port for ADD_LAT cycles, then the result is registered and returned with a valid/ready handshake.
- Sits between the requester blocks and the single csa instance, which is connected externally through the add_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/sum width; must match the csa instance.
- ADD_LAT, 1, cycles operands are held on add_* before add_sum/add_cout are sampled (1..15); covers the csa multicycle path.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high with stable operands until the matching gnt bit is seen.
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_cin  in  NUM_REQ  per-requester carry-in.
- gnt  out  NUM_REQ  one-hot grant, combinational; operands are captured on the edge ending the gnt cycle.
- add_a  out  WIDTH  to csa A.
- add_b  out  WIDTH  to csa B.
- add_cin  out  1  to csa Cin.
- add_sum  in  WIDTH  from csa Sum[WIDTH-1:0].
- add_cout  in  1  from csa Cout.
- rsp_valid  out  1  result valid.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, lat_cnt=0.
  - Operand registers are 0, so add_a=0, add_b=0, add_cin=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, gnt=0.
  - Reset mid-operation abandons the transaction; no response is produced.
- Three-state FSM:
  - IDLE
    - gnt is nonzero only in IDLE, and only when req≠0.
    - Winner = first set req bit scanning from rr_ptr upward, wrapping at NUM_REQ.
    - On the edge: latch req_a/req_b/req_cin and index of the winner, set lat_cnt=ADD_LAT-1, rr_ptr=(winner+1) mod NUM_REQ, go to EXEC.
    - req=0: stay in IDLE; rr_ptr unchanged.
  - EXEC
    - add_* driven from the operand registers; gnt=0.
    - lat_cnt≠0: decrement.
    - lat_cnt=0: capture add_sum→rsp_sum, add_cout→rsp_cout, latched index→rsp_id; set rsp_valid=1; go to RESP.
  - RESP
    - rsp_valid=1; rsp_* held stable until accepted.
    - rsp_ready=1 on the edge: rsp_valid←0, go to IDLE.
    - rsp_ready=0: hold.
- Latency:
  - gnt in cycle T → rsp_valid rises in cycle T+1+ADD_LAT.
  - Minimum issue interval is ADD_LAT+2 cycles.
- Outputs hold their values outside their active states:
  - add_a, add_b and add_cin keep the last operands; they do not toggle outside EXEC.
  - rsp_sum, rsp_cout and rsp_id keep the last response after acceptance.
- Arithmetic:
  - Width and overflow come from the csa; no arithmetic is done in this block.
  - {rsp_cout, rsp_sum} = A + B + cin, modulo 2^(WIDTH+1).
- Requests that drop while not granted are forgotten; no queueing.
- Any req bit ≥ NUM_REQ does not exist; gnt is always one-hot or zero.

Test Plan:
1. Only req[2], A=5, B=7, cin=1, ADD_LAT=1, rsp_ready=1 → gnt=0100 in cycle T; rsp_valid in cycle T+2 with rsp_sum=13, rsp_cout=0, rsp_id=2; IDLE at T+3.
2. req=1111 held constant, rsp_ready=1, from reset → grant order 0,1,2,3,0; consecutive gnts spaced 3 cycles apart; each rsp_id matches its grant.
3. A=32'hFFFFFFFF, B=0, cin=1 → rsp_sum=0, rsp_cout=1; A=B=32'h80000000, cin=0 → rsp_sum=0, rsp_cout=1.
4. rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, gnt=0 despite pending req; rsp_ready=1 → accepted next edge, next gnt the cycle after.
5. rst_n pulsed low during EXEC → all outputs 0 immediately (async); rr_ptr=0; no rsp_valid after release; req[0] wins next.
6. ADD_LAT=3, A=100, B=23 → add_a/add_b stable for 3 cycles; rsp_valid at T+4 with rsp_sum=123.
